// File: rtl/matrix_element_sequencer.sv
// Walks a NUM_ROWS x ROW_LEN tile for NUM_VECTORS vectors, one element per enabled cycle.
// Optional macro MATRIX_SEQ_TRANSPOSE_EN adds a 'transpose' input for column-major traversal.
module matrix_element_sequencer #(
  parameter int ROW_LEN     = 3,
  parameter int NUM_ROWS    = 3,
  parameter int NUM_VECTORS = 4,
  parameter int ELEM_W      = (ROW_LEN * NUM_ROWS > 1) ? $clog2(ROW_LEN * NUM_ROWS) : 1,
  parameter int COL_W       = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1,
  parameter int ROW_W       = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  parameter int VEC_W       = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              en,
  input  logic              clear,
`ifdef MATRIX_SEQ_TRANSPOSE_EN
  input  logic              transpose,
`endif
  output logic [ELEM_W-1:0] element_index,
  output logic [COL_W-1:0]  col_index,
  output logic [ROW_W-1:0]  row_index,
  output logic [VEC_W-1:0]  vector_index,
  output logic              elem_valid,
  output logic              last_in_row,
  output logic              last_in_vector,
  output logic              new_row,
  output logic              new_vector,
  output logic              done,
  output logic              busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_LEN - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VECTORS - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1'b1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1'b1);
  localparam logic [VEC_W-1:0] VEC_ONE  = VEC_W'(1'b1);

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [ELEM_W-1:0] elem_q, elem_d;
  logic              new_row_q, new_row_d;
  logic              new_vector_q, new_vector_d;
  logic              done_q, done_d;
  logic              col_major_s;
  logic              last_col_s, last_row_s, last_vec_s, end_vec_s;

`ifdef MATRIX_SEQ_TRANSPOSE_EN
  logic              transpose_q, transpose_d;
  assign col_major_s = transpose_q;
`else
  assign col_major_s = 1'b0;
`endif

  assign last_col_s = (col_q == COL_LAST);
  assign last_row_s = (row_q == ROW_LAST);
  assign last_vec_s = (vec_q == VEC_LAST);
  assign end_vec_s  = last_col_s && last_row_s;

  // Next-state, index advance and strobe generation
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    vec_d        = vec_q;
    new_row_d    = 1'b0;
    new_vector_d = 1'b0;
    done_d       = 1'b0;
`ifdef MATRIX_SEQ_TRANSPOSE_EN
    transpose_d  = transpose_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
`ifdef MATRIX_SEQ_TRANSPOSE_EN
          transpose_d = transpose;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (en) begin
          // The fast axis is col in row-major order and row in column-major order
          if (col_major_s) begin
            if (last_row_s) begin
              row_d = {ROW_W{1'b0}};
              col_d = last_col_s ? {COL_W{1'b0}} : (col_q + COL_ONE);
            end else begin
              row_d = row_q + ROW_ONE;
            end
            new_row_d = last_row_s;
          end else begin
            if (last_col_s) begin
              col_d = {COL_W{1'b0}};
              row_d = last_row_s ? {ROW_W{1'b0}} : (row_q + ROW_ONE);
            end else begin
              col_d = col_q + COL_ONE;
            end
            new_row_d = last_col_s;
          end
          if (end_vec_s) begin
            vec_d        = last_vec_s ? {VEC_W{1'b0}} : (vec_q + VEC_ONE);
            new_vector_d = 1'b1;
          end else begin
            vec_d = vec_q;
          end
          if (end_vec_s && last_vec_s) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        col_d   = {COL_W{1'b0}};
        row_d   = {ROW_W{1'b0}};
        vec_d   = {VEC_W{1'b0}};
      end
    endcase
    // Abort returns to the reset indices and suppresses any strobe from this cycle
    if (clear) begin
      state_d      = IDLE;
      col_d        = {COL_W{1'b0}};
      row_d        = {ROW_W{1'b0}};
      vec_d        = {VEC_W{1'b0}};
      new_row_d    = 1'b0;
      new_vector_d = 1'b0;
      done_d       = 1'b0;
    end else begin
      state_d = state_d;
    end
    elem_d = ELEM_W'(int'(row_d) * ROW_LEN + int'(col_d));
  end

  // State, index and strobe registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      col_q        <= {COL_W{1'b0}};
      row_q        <= {ROW_W{1'b0}};
      vec_q        <= {VEC_W{1'b0}};
      elem_q       <= {ELEM_W{1'b0}};
      new_row_q    <= 1'b0;
      new_vector_q <= 1'b0;
      done_q       <= 1'b0;
`ifdef MATRIX_SEQ_TRANSPOSE_EN
      transpose_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      vec_q        <= vec_d;
      elem_q       <= elem_d;
      new_row_q    <= new_row_d;
      new_vector_q <= new_vector_d;
      done_q       <= done_d;
`ifdef MATRIX_SEQ_TRANSPOSE_EN
      transpose_q  <= transpose_d;
`endif
    end
  end

  assign element_index  = elem_q;
  assign col_index      = col_q;
  assign row_index      = row_q;
  assign vector_index   = vec_q;
  assign busy           = (state_q == RUN);
  assign elem_valid     = (state_q == RUN);
  assign last_in_row    = elem_valid && (col_major_s ? last_row_s : last_col_s);
  assign last_in_vector = elem_valid && end_vec_s;
  assign new_row        = new_row_q;
  assign new_vector     = new_vector_q;
  assign done           = done_q;

endmodule
